// File: rtl/dither_write_combiner.sv
// dither_write_combiner: coalesces engine byte writes into word writes through a FIFO, draining before reads
module dither_write_combiner #(
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 15,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              de_req,
  output logic              de_ack,
  input  logic [ADDR_W-1:0] de_addr,
  input  logic [3:0]        de_nbyte,
  input  logic              de_rnw,
  input  logic [31:0]       de_w_data,
  output logic [31:0]       de_r_data,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_nbyte,
  output logic              mem_rnw,
  output logic [31:0]       mem_w_data,
  input  logic [31:0]       mem_r_data,
  input  logic              flush,
  output logic              busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {WR, DRAIN, RD, DONE} state_t;
  state_t state;
  logic acc_valid;
  logic [ADDR_W-1:0] acc_addr;
  logic [3:0] acc_nbyte;
  logic [31:0] acc_data;
  logic [TW-1:0] idle;
  logic fl_pend;
  logic [ADDR_W-1:0] f_addr [DEPTH];
  logic [3:0] f_nbyte [DEPTH];
  logic [31:0] f_data [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic has, not_full, wr, hit, fl, tmo, evict, wr_full, drop, push, pop, draining, rd;
  logic [3:0] m_nbyte;
  logic [31:0] m_data;
  assign has = count != '0;
  assign not_full = count != CW'(DEPTH);
  assign wr = ~rst & (state == WR) & de_req & ~de_rnw & not_full;
  assign de_ack = wr | (~rst & (state == DONE));
  assign hit = acc_valid & (de_addr == acc_addr);
  assign m_nbyte = (hit ? acc_nbyte : 4'hf) & de_nbyte;
  always_comb begin
    m_data = '0;
    for (int i = 0; i < 4; i++)
      m_data[8*i +: 8] = de_nbyte[i] ? (hit ? acc_data[8*i +: 8] : 8'h00) : de_w_data[8*i +: 8];
  end
  assign fl = flush | fl_pend;
  assign tmo = idle >= TW'(TIMEOUT - 1);
  assign evict = wr & acc_valid & ~hit;
  assign wr_full = wr & ~evict & (m_nbyte == 4'h0);
  assign drop = ~wr & acc_valid & not_full & ((acc_nbyte == 4'h0) | fl | tmo | (state == DRAIN));
  assign push = evict | wr_full | drop;
  assign draining = ((state == WR) | (state == DRAIN)) & has;
  assign rd = state == RD;
  assign pop = draining & mem_ack;
  assign mem_req = draining | rd;
  assign mem_rnw = rd;
  assign mem_addr = rd ? de_addr : draining ? f_addr[rp] : '0;
  assign mem_nbyte = rd ? de_nbyte : draining ? f_nbyte[rp] : 4'hf;
  assign mem_w_data = draining ? f_data[rp] : '0;
  assign busy = acc_valid | has | (state != WR);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WR;
      acc_valid <= 1'b0;
      acc_addr <= '0;
      acc_nbyte <= 4'hf;
      acc_data <= '0;
      idle <= '0;
      fl_pend <= 1'b0;
      wp <= '0;
      rp <= '0;
      count <= '0;
      de_r_data <= '0;
    end else begin
      if (push) begin
        f_addr[wp] <= wr_full ? de_addr : acc_addr;
        f_nbyte[wp] <= wr_full ? m_nbyte : acc_nbyte;
        f_data[wp] <= wr_full ? m_data : acc_data;
        wp <= wp + AW'(1);
      end
      if (pop)
        rp <= rp + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (wr) begin
        acc_valid <= ~wr_full;
        acc_addr <= de_addr;
        acc_nbyte <= m_nbyte;
        acc_data <= m_data;
      end else if (drop)
        acc_valid <= 1'b0;
      idle <= wr ? '0 : (idle == TW'(TIMEOUT)) ? idle : idle + TW'(1);
      fl_pend <= fl & acc_valid & ~wr & ~drop;
      if (rd & mem_ack)
        de_r_data <= mem_r_data;
      state <= (state == WR && de_req && de_rnw) ? DRAIN :
               (state == DRAIN && !acc_valid && !has) ? RD :
               (rd && mem_ack) ? DONE :
               (state == DONE) ? WR : state;
    end
  end
endmodule

// File: tb/tb_dither_write_combiner.sv
// tb_dither_write_combiner: directed and randomized checks against a byte-merging reference model
module tb_dither_write_combiner;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 15;
  localparam int ADDR_W = 18;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic de_req = 1'b0, de_rnw = 1'b0, flush = 1'b0, mem_ack = 1'b0;
  logic [ADDR_W-1:0] de_addr = '0;
  logic [3:0] de_nbyte = 4'hf;
  logic [31:0] de_w_data = '0, mem_r_data = '0;
  logic de_ack, mem_req, mem_rnw, busy;
  logic [31:0] de_r_data, mem_w_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0] mem_nbyte;
  dither_write_combiner #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .de_req(de_req), .de_ack(de_ack), .de_addr(de_addr),
    .de_nbyte(de_nbyte), .de_rnw(de_rnw), .de_w_data(de_w_data), .de_r_data(de_r_data),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_nbyte(mem_nbyte),
    .mem_rnw(mem_rnw), .mem_w_data(mem_w_data), .mem_r_data(mem_r_data),
    .flush(flush), .busy(busy)
  );
  always #5 clk = ~clk;
  int n_vec = 0, n_err = 0, beats = 0, n_pushed = 0, ack_pct = 100, lat;
  logic rd_fix = 1'b0;
  logic [31:0] last_rd = '0;
  logic [54:0] exp_q [$];
  logic [54:0] mon_e;
  logic acc_v = 1'b0;
  logic [ADDR_W-1:0] acc_a;
  logic [3:0] acc_nb;
  logic [31:0] acc_d;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] lanes(input logic [31:0] d, input logic [3:0] nb);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (!nb[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction
  task automatic expect_beat(input logic rnw, input logic [ADDR_W-1:0] a, input logic [3:0] nb, input logic [31:0] d);
    exp_q.push_back({rnw, a, nb, rnw ? 32'h0 : lanes(d, nb)});
    n_pushed++;
  endtask
  task automatic m_write(input logic [ADDR_W-1:0] a, input logic [3:0] nb, input logic [31:0] d);
    if (acc_v && a != acc_a) begin
      expect_beat(1'b0, acc_a, acc_nb, acc_d);
      acc_v = 1'b0;
    end
    if (!acc_v) begin
      acc_v = 1'b1;
      acc_a = a;
      acc_nb = 4'hf;
      acc_d = '0;
    end
    for (int i = 0; i < 4; i++)
      if (!nb[i]) begin
        acc_d[8*i +: 8] = d[8*i +: 8];
        acc_nb[i] = 1'b0;
      end
    if (acc_nb == 4'h0) begin
      expect_beat(1'b0, acc_a, acc_nb, acc_d);
      acc_v = 1'b0;
    end
  endtask
  task automatic m_flush();
    if (acc_v) expect_beat(1'b0, acc_a, acc_nb, acc_d);
    acc_v = 1'b0;
  endtask
  always @(negedge clk)
    if (!rst && mem_req && mem_ack) begin
      beats++;
      if (mem_rnw) last_rd = mem_r_data;
      if (exp_q.size() == 0) check("mem_unexpected", beats, n_pushed);
      else begin
        mon_e = exp_q.pop_front();
        check("mem_beat", {mem_rnw, mem_addr, mem_nbyte, mem_rnw ? 32'h0 : lanes(mem_w_data, mem_nbyte)}, mon_e);
      end
    end
  task automatic tick();
    @(posedge clk);
    #1;
    mem_ack = ($urandom_range(0, 99) < ack_pct);
    mem_r_data = rd_fix ? 32'hDEADBEEF : $urandom;
  endtask
  task automatic gap(input int n);
    de_req = 1'b0;
    repeat (n) tick();
  endtask
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [3:0] nb, input logic [31:0] d, input logic fl);
    logic ok;
    ok = 1'b0;
    de_req = 1'b1;
    de_rnw = 1'b0;
    de_addr = a;
    de_nbyte = nb;
    de_w_data = d;
    flush = fl;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      ok = de_ack;
      tick();
      flush = 1'b0;
    end
    de_req = 1'b0;
    if (ok) m_write(a, nb, d);
    else check("wr_accept_timeout", ok, 1);
  endtask
  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [3:0] nb);
    logic ok;
    ok = 1'b0;
    m_flush();
    expect_beat(1'b1, a, nb, 32'h0);
    de_req = 1'b1;
    de_rnw = 1'b1;
    de_addr = a;
    de_nbyte = nb;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk);
      ok = de_ack;
      if (ok) check("rd_data", de_r_data, last_rd);
      tick();
    end
    de_req = 1'b0;
    de_rnw = 1'b0;
    if (!ok) check("rd_ack_timeout", ok, 1);
  endtask
  initial begin
    #600000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_de_ack", de_ack, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_rnw", mem_rnw, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_nbyte", mem_nbyte, 4'hf);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_w_data", mem_w_data, 0);
    check("rst_de_r_data", de_r_data, 0);
    do_write(18'h10, 4'b1110, 32'h0000_0011, 1'b0);
    do_write(18'h10, 4'b1101, 32'h0000_2200, 1'b0);
    do_write(18'h10, 4'b1011, 32'h0033_0000, 1'b0);
    do_write(18'h10, 4'b0111, 32'h4400_0000, 1'b0);
    gap(4);
    check("fill_beats", beats, n_pushed);
    do_write(18'h5, 4'b1110, 32'h0000_00a5, 1'b0);
    do_write(18'h6, 4'b1110, 32'h0000_00a6, 1'b0);
    m_flush();
    @(negedge clk);
    check("addr5_issue", {mem_req, mem_addr}, {1'b1, 18'h5});
    lat = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      tick();
      @(negedge clk);
      if (mem_req && mem_addr == 18'h6) lat = n;
    end
    check("timeout_latency", lat, TIMEOUT);
    gap(3);
    ack_pct = 0;
    tick();
    for (int i = 0; i < 4; i++) do_write(18'h80 + 18'(i), 4'h0, $urandom, 1'b0);
    de_req = 1'b1;
    de_addr = 18'h84;
    de_nbyte = 4'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_stall", de_ack, 0);
      tick();
    end
    ack_pct = 100;
    do_write(18'h84, 4'h0, 32'hcafe_0084, 1'b0);
    gap(8);
    check("bp_beats", beats, n_pushed);
    do_write(18'h40, 4'b1100, 32'h0000_1234, 1'b0);
    do_write(18'h41, 4'b0011, 32'h5678_0000, 1'b1);
    gap(6);
    check("flush_nodup", beats, n_pushed);
    m_flush();
    gap(TIMEOUT + 6);
    rd_fix = 1'b1;
    do_write(18'h7, 4'b1100, 32'h0000_7777, 1'b0);
    do_read(18'h7, 4'h0);
    check("rd_deadbeef", de_r_data, 32'hDEADBEEF);
    @(negedge clk);
    check("rd_ack_once", de_ack, 0);
    rd_fix = 1'b0;
    gap(3);
    ack_pct = 0;
    tick();
    for (int i = 0; i < 3; i++) do_write(18'h100 + 18'(i), 4'h0, $urandom, 1'b0);
    do_write(18'h200, 4'b1110, $urandom, 1'b0);
    de_req = 1'b1;
    de_rnw = 1'b1;
    de_addr = 18'h300;
    de_nbyte = 4'h0;
    tick();
    tick();
    rst = 1'b1;
    de_req = 1'b0;
    de_rnw = 1'b0;
    @(negedge clk);
    check("rst_mid_ack", de_ack, 0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    acc_v = 1'b0;
    n_pushed = beats;
    @(negedge clk);
    check("rst_mid_mem_req", mem_req, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_de_ack", de_ack, 0);
    ack_pct = 100;
    gap(20);
    check("rst_stale", beats, n_pushed);
    for (int k = 0; k < 250; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 72) begin
        ack_pct = 60;
        do_write(18'h20 + ADDR_W'($urandom_range(0, 3)), 4'($urandom), $urandom, 1'b0);
        gap($urandom_range(0, 3));
      end else if (r < 84) begin
        ack_pct = 100;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        m_flush();
        gap(4);
      end else if (r < 92) begin
        ack_pct = 100;
        m_flush();
        gap(TIMEOUT + 6);
      end else begin
        ack_pct = $urandom_range(30, 100);
        do_read(18'h20 + ADDR_W'($urandom_range(0, 3)), 4'($urandom));
      end
    end
    m_flush();
    ack_pct = 100;
    gap(TIMEOUT + 10);
    check("end_queue", exp_q.size(), 0);
    check("end_busy", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
